rr_channel_muxer: RTL

Parametrised, registered N-to-1 channel multiplexer with valid/ready handshakes and round-robin selection. It generalises the fixed 2-to-1 selector: the select command is no longer an external input but comes from an internal fair arbiter over N producer channels, each W bits wide. It sits between several producers and one shared consumer, with a single output register giving one-cycle latency and full throughput.

---
 rtl/rr_channel_muxer_pkg.sv | 25 ++
 rtl/rr_channel_muxer_arbiter.sv | 43 ++++
 rtl/rr_channel_muxer.sv | 114 +++++++++++
 3 files changed

// File: rtl/rr_channel_muxer_pkg.sv
// Shared definitions for the round-robin channel muxer: index-width helper,
// packet-lock state encoding and register reset values.
package rr_channel_muxer_pkg;

    // Smallest w with 2**w >= n; at least 1 so a 2-channel muxer still has an index bit.
    function automatic int sw_calc(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    localparam logic RST_VALID = 1'b0;
    localparam logic RST_LAST  = 1'b0;
    localparam int   RST_CHAN  = 0;
    localparam int   RST_PTR   = 0;

endpackage

// File: rtl/rr_channel_muxer_arbiter.sv
// Combinational round-robin arbiter: rotate requests so ptr sits at bit 0,
// pick the lowest set bit, rotate the one-hot pick back to channel order.
module rr_arbiter
    import rr_channel_muxer_pkg::*;
#(
    parameter int N = 4,
    localparam int SW = sw_calc(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx
);

    logic [N-1:0] rotated;
    logic [N-1:0] pick;

    // Doubling the vector turns the modulo-N rotation into a plain shift.
    assign rotated = N'({req, req} >> ptr);

    // NOTE: every variable written in an always_comb gets a default first,
    // otherwise paths that skip the assignment infer a latch.
    always_comb begin
        pick = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                pick = N'(1) << j;
            end
        end
    end

    assign grant = N'(({pick, pick} << ptr) >> N);

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                grant_idx = SW'(k);
            end
        end
    end

endmodule

// File: rtl/rr_channel_muxer.sv
// Registered N-to-1 valid/ready muxer with round-robin channel selection.
// Define RR_CHANNEL_MUXER_HOLD_EN to add in_last/out_last packet locking.
module rr_channel_muxer
    import rr_channel_muxer_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = sw_calc(N)
) (
    input  logic           clock,
    input  logic           reset_,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
`ifdef RR_CHANNEL_MUXER_HOLD_EN
    input  logic [N-1:0]   in_last,
    output logic           out_last,
`endif
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_next;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic          load_en;
    logic          accept;

    // The register can refill in the same cycle it is drained.
    assign load_en = ~out_valid | out_ready;

`ifdef RR_CHANNEL_MUXER_HOLD_EN
    lock_state_e   lock_state;
    lock_state_e   lock_next;
    logic [SW-1:0] lock_chan;

    // While a packet is open only its own channel may compete.
    always_comb begin
        req = in_valid;
        if (lock_state == LOCKED) begin
            req = in_valid & (N'(1) << lock_chan);
        end
    end

    always_comb begin
        lock_next = lock_state;
        if (accept) begin
            lock_next = in_last[grant_idx] ? UNLOCKED : LOCKED;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            lock_state <= UNLOCKED;
            lock_chan  <= SW'(RST_CHAN);
            out_last   <= RST_LAST;
        end else begin
            lock_state <= lock_next;
            if (accept) begin
                lock_chan <= grant_idx;
                out_last  <= in_last[grant_idx];
            end
        end
    end
`else
    assign req = in_valid;
`endif

    rr_arbiter #(
        .N(N)
    ) u_arbiter (
        .req      (req),
        .ptr      (ptr),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    // Gating with reset_ keeps producers from handing over words that reset would discard.
    assign in_ready = grant & {N{load_en & reset_}};
    assign accept   = reset_ & load_en & (|req);

    assign ptr_next = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            out_valid <= RST_VALID;
            out_data  <= '0;
            out_chan  <= SW'(RST_CHAN);
            ptr       <= SW'(RST_PTR);
        end else if (load_en) begin
            if (|req) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_idx*W +: W];
                out_chan  <= grant_idx;
`ifdef RR_CHANNEL_MUXER_HOLD_EN
                if (in_last[grant_idx]) begin
                    ptr <= ptr_next;
                end
`else
                ptr <= ptr_next;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
